grid_io_tile_cfg_buffered: RTL

//   Parametrised I/O grid tile with NUM_IO pad subtiles sharing one configuration chain.
//   The chain is double-buffered: shifting goes into a shadow register, and an automatic

---
 rtl/grid_io_tile_cfg_buffered.sv | 131 +++++++++++++
 1 files changed

// File: rtl/grid_io_tile_cfg_buffered.sv
// I/O grid tile: NUM_IO pad subtiles configured through a double-buffered scan chain.
// A full frame lands in the shadow register and is then committed to the active config.
module grid_io_tile_cfg_buffered #(
    parameter int NUM_IO = 4
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              cfg_clear,
    input  logic              isol_n,
    input  logic [NUM_IO-1:0] io_outpad,
    input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
    output logic              ccff_tail,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
    output logic [NUM_IO-1:0] io_inpad
);

    localparam int CFG_BITS  = 2;
    localparam int CHAIN_LEN = NUM_IO * CFG_BITS;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CHAIN_LEN-1:0]   shadow;
    logic [CHAIN_LEN-1:0]   active;
    logic [NUM_IO-1:0]      dir_vec;
    logic [NUM_IO-1:0]      inv_vec;

    // The shadow keeps shifting regardless of frame state so downstream tiles see the stream.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shadow <= '0;
        end else if (ccff_en) begin
            shadow <= {shadow[CHAIN_LEN-2:0], ccff_head};
        end
    end

    assign ccff_tail = shadow[CHAIN_LEN-1];
    assign cfg_busy  = (state != IDLE);

    // NOTE: non-blocking assignments make every register sample pre-edge values, so the
    // commit captures the complete frame even when the next frame's first bit shifts on
    // the same edge.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            active   <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (cfg_clear) begin
                bit_cnt <= '0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ccff_en) begin
                            if (CHAIN_LEN == 1) begin
                                bit_cnt <= '0;
                                state   <= COMMIT;
                            end else begin
                                bit_cnt <= CNT_W'(1);
                                state   <= SHIFT;
                            end
                        end
                    end
                    SHIFT: begin
                        if (ccff_en) begin
                            if (bit_cnt == LAST_CNT) begin
                                bit_cnt <= '0;
                                state   <= COMMIT;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    COMMIT: begin
                        active   <= shadow;
                        cfg_done <= 1'b1;
                        if (ccff_en) begin
                            if (CHAIN_LEN == 1) begin
                                bit_cnt <= '0;
                                state   <= COMMIT;
                            end else begin
                                bit_cnt <= CNT_W'(1);
                                state   <= SHIFT;
                            end
                        end else begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        dir_vec              = '0;
        inv_vec              = '0;
        gfpga_pad_io_soc_dir = '0;
        gfpga_pad_io_soc_out = '0;
        io_inpad             = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            dir_vec[i] = active[CFG_BITS*i + 0];
            inv_vec[i] = active[CFG_BITS*i + 1];
            // Isolated pads are forced to input with no drive and no fabric data.
            gfpga_pad_io_soc_dir[i] = ~isol_n | dir_vec[i];
            gfpga_pad_io_soc_out[i] = isol_n & ~dir_vec[i] & io_outpad[i];
            io_inpad[i]             = isol_n & dir_vec[i] & (gfpga_pad_io_soc_in[i] ^ inv_vec[i]);
        end
    end

endmodule
